// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: holds the delay line and coefficients, issues one multiply per tap
// to the shared ALU, accumulates the returned products and presents a saturated output.
module fir_tap_sequencer #(
  parameter int NTAPS   = 8,
  parameter int ALU_LAT = 2,
  parameter int ACC_W   = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [15:0]              coef_wdata,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_data,
  output logic [15:0]              alu_a,
  output logic [15:0]              alu_b,
  output logic [1:0]               alu_op_sel,
  input  logic [31:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     busy
);

  localparam int AW = $clog2(NTAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                   r_state;
  logic [15:0]              r_buf  [NTAPS];
  logic [15:0]              r_coef [NTAPS];
  logic [AW-1:0]            r_wr_ptr;
  logic [AW:0]              r_tap;
  logic [ALU_LAT-1:0]       r_tag;
  logic signed [ACC_W-1:0]  r_acc;
  logic [15:0]              r_alu_a;
  logic [15:0]              r_alu_b;
  logic [1:0]               r_alu_op;
  logic                     r_out_valid;
  logic [31:0]              r_out_data;

  logic                     w_issue;
  logic                     w_accept;
  logic                     w_coef_wr;
  logic [ALU_LAT-1:0]       w_tag_shift;
  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic [31:0]              w_sat;
  logic [AW-1:0]            w_rd_idx;

  assign w_issue     = (r_alu_op == 2'b01);
  assign w_tag_shift = ALU_LAT'({r_tag, w_issue});
  assign w_prod      = {{(ACC_W-32){alu_result[31]}}, alu_result};
  assign w_acc_next  = r_tag[ALU_LAT-1] ? (r_acc + w_prod) : r_acc;
  assign w_rd_idx    = r_wr_ptr - r_tap[AW-1:0];
  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_coef_wr   = coef_we && (r_state == IDLE);

  // Saturate the accumulator value including any product landing this cycle
  always_comb begin
    w_sat = w_acc_next[31:0];
    if (w_acc_next > SAT_MAX)      w_sat = 32'h7FFF_FFFF;
    else if (w_acc_next < SAT_MIN) w_sat = 32'h8000_0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        r_buf[i]  <= '0;
        r_coef[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_tap       <= '0;
      r_tag       <= '0;
      r_acc       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_tag <= w_tag_shift;
      r_acc <= w_acc_next;
      if (w_coef_wr) r_coef[coef_addr] <= coef_wdata;
      unique case (r_state)
        IDLE: if (w_accept) begin
          // Tap 0 uses the incoming sample and a same-cycle coefficient write directly
          r_buf[r_wr_ptr] <= in_data;
          r_acc    <= '0;
          r_alu_a  <= in_data;
          r_alu_b  <= (w_coef_wr && coef_addr == '0) ? coef_wdata : r_coef[0];
          r_alu_op <= 2'b01;
          r_tap    <= (AW+1)'(1);
          r_state  <= ISSUE;
        end
        ISSUE: begin
          if (r_tap == (AW+1)'(NTAPS)) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 2'b00;
            r_state  <= DRAIN;
          end else begin
            r_alu_a <= r_buf[w_rd_idx];
            r_alu_b <= r_coef[r_tap[AW-1:0]];
            r_tap   <= r_tap + 1'b1;
          end
        end
        DRAIN: if (w_tag_shift == '0) begin
          r_out_data  <= w_sat;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op_sel = r_alu_op;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer with a behavioural fixed-latency multiplier.
module tb_fir_tap_sequencer;
  localparam int NTAPS   = 8;
  localparam int ALU_LAT = 2;
  localparam int ACC_W   = 40;
  localparam int AW      = $clog2(NTAPS);

  logic          clk;
  logic          rst;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [15:0]   coef_wdata;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [1:0]    alu_op_sel;
  logic [31:0]   alu_result;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] alu_pipe [ALU_LAT];

  fir_tap_sequencer #(.NTAPS(NTAPS), .ALU_LAT(ALU_LAT), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_sel(alu_op_sel), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: signed 16x16 product returned ALU_LAT cycles after the operands
  always @(posedge clk) begin
    alu_pipe[0] <= $signed({{16{alu_a[15]}}, alu_a}) * $signed({{16{alu_b[15]}}, alu_b});
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_result = alu_pipe[ALU_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: every output handshake pops one expected value
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %0d, expected no output", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", out_data, mon_exp);
      end
    end
  end

  task automatic write_coef(input int k, input int v);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = AW'(k); coef_wdata = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic load_h(input int base, input int step);
    for (int k = 0; k < NTAPS; k++) write_coef(k, base + k * step);
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin @(negedge clk); w++; end
    if (!in_ready) fail_timeout("in_ready");
  endtask

  // Returns #1 after the accepting edge (cycle 0), so the next negedge is cycle 1
  task automatic send(input int x, input int e, input bit push);
    wait_ready();
    in_valid = 1'b1; in_data = 16'(x);
    if (push) exp_q.push_back(32'(e));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin @(negedge clk); w++; end
    if (exp_q.size() != 0) begin
      fail_timeout("drain");
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int imp_exp  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
  int step_exp [9] = '{100, 300, 600, 1000, 1500, 2100, 2800, 3600, 3600};
  int op_cnt, op_first, op_last, first_valid, w;
  logic [31:0] hold;

  initial begin
    rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_alu_op", 32'(alu_op_sel), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // Impulse with timing of the first sample
    load_h(1, 1);
    send(1, imp_exp[0], 1'b1);
    op_cnt = 0; op_first = 0; op_last = 0; first_valid = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_cycle1", 32'(busy), 1);
      if (alu_op_sel == 2'b01) begin
        op_cnt++;
        if (op_first == 0) op_first = n;
        op_last = n;
      end
      if (out_valid && first_valid == 0) first_valid = n;
    end
    check("mul_op_count", 32'(op_cnt), 8);
    check("mul_op_first_cycle", 32'(op_first), 1);
    check("mul_op_last_cycle", 32'(op_last), 8);
    check("out_valid_latency", 32'(first_valid), 11);
    for (int i = 1; i < 9; i++) send(0, imp_exp[i], 1'b1);
    wait_drain();

    // Step response
    do_reset();
    load_h(1, 1);
    for (int i = 0; i < 9; i++) send(100, step_exp[i], 1'b1);
    wait_drain();

    // Positive saturation
    do_reset();
    load_h(32767, 0);
    send(32767, 1073676289, 1'b1);
    send(32767, 2147352578, 1'b1);
    send(32767, 32'h7FFF_FFFF, 1'b1);
    send(32767, 32'h7FFF_FFFF, 1'b1);
    wait_drain();

    // Negative saturation
    do_reset();
    load_h(-32768, 0);
    send(32767, -1073709056, 1'b1);
    send(32767, -2147418112, 1'b1);
    send(32767, 32'h8000_0000, 1'b1);
    send(32767, 32'h8000_0000, 1'b1);
    wait_drain();

    // Backpressure: output held, in_valid pulses ignored
    do_reset();
    load_h(1, 1);
    out_ready = 1'b0;
    send(1, 1, 1'b1);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    if (!out_valid) fail_timeout("bp_out_valid");
    hold = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_data_stable", out_data, hold);
      check("bp_in_ready", 32'(in_ready), 0);
      in_valid = (i % 2 == 0);
      in_data = 16'd555;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(0, 2, 1'b1);
    wait_drain();

    // Coefficient write while busy is ignored; in IDLE with acceptance it applies
    do_reset();
    load_h(1, 1);
    send(1, 1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'd99;
    @(negedge clk);
    coef_we = 1'b0;
    for (int i = 1; i < 8; i++) send(0, imp_exp[i], 1'b1);
    wait_drain();
    wait_ready();
    in_valid = 1'b1; in_data = 16'd1;
    coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'd99;
    exp_q.push_back(32'd99);
    @(posedge clk); #1;
    in_valid = 1'b0; coef_we = 1'b0;
    wait_drain();

    // Reset during tap 4
    do_reset();
    load_h(1, 1);
    send(1, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("tap4_alu_op", 32'(alu_op_sel), 1);
    check("tap4_alu_b", 32'(alu_b), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_alu_op", 32'(alu_op_sel), 0);
    check("midrst_busy", 32'(busy), 0);
    load_h(1, 1);
    for (int i = 0; i < 8; i++) send(i == 0 ? 1 : 0, imp_exp[i], 1'b1);
    wait_drain();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
